// File: rtl/sp_guarded.sv
// Guarded full-descending stack pointer with range limits, load and a FAULT freeze.
// Optional low-water-mark register enabled by defining SP_WATERMARK_EN.
//
//   state   | meaning
//   S_RUN   | normal push/pop/load operation
//   S_FAULT | frozen after overflow/underflow/bad load; waits for clr_fault or a valid ld
module sp_guarded #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   TOP_ADDR    = 'h01FF,
  parameter logic [WIDTH-1:0]   BOTTOM_ADDR = 'h0100,
  parameter logic [WIDTH-1:0]   STEP        = 'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [WIDTH-1:0] wm,
  input  logic             wm_clr
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_OVF   = 2'b01;
  localparam logic [1:0] CAUSE_UNF   = 2'b10;
  localparam logic [1:0] CAUSE_BADLD = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;

  logic [WIDTH:0]   top_gap, bot_gap;
  logic             ld_ok;

  // Widened subtraction keeps the limit tests free of wrap-around.
  assign top_gap = {1'b0, TOP_ADDR} - {1'b0, out_q};
  assign bot_gap = {1'b0, out_q} - {1'b0, BOTTOM_ADDR};
  assign empty   = top_gap < {1'b0, STEP};
  assign full    = bot_gap < {1'b0, STEP};
  assign ld_ok   = ({1'b0, ld_val} >= {1'b0, BOTTOM_ADDR}) &&
                   ({1'b0, ld_val} <= {1'b0, TOP_ADDR});

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    fault_d = fault_q;
    cause_d = cause_q;
    unique case (state_q)
      S_RUN: begin
        if (ld) begin
          if (ld_ok) begin
            out_d = ld_val;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_BADLD;
          end
        end else if (dec && !inc) begin
          if (full) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_OVF;
          end else begin
            out_d = out_q - STEP;
          end
        end else if (inc && !dec) begin
          if (empty) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_UNF;
          end else begin
            out_d = out_q + STEP;
          end
        end
      end
      S_FAULT: begin
        // A load overrides clr_fault here: it alone decides the outcome.
        if (ld) begin
          if (ld_ok) begin
            out_d   = ld_val;
            state_d = S_RUN;
            fault_d = 1'b0;
            cause_d = CAUSE_NONE;
          end else begin
            cause_d = CAUSE_BADLD;
          end
        end else if (clr_fault) begin
          state_d = S_RUN;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      out_q   <= TOP_ADDR;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign out         = out_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

`ifdef SP_WATERMARK_EN
  logic [WIDTH-1:0] wm_q, wm_d;

  always_comb begin
    wm_d = wm_q;
    if (wm_clr) begin
      wm_d = out_d;
    end else if (out_d < wm_q) begin
      wm_d = out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wm_q <= TOP_ADDR;
    end else begin
      wm_q <= wm_d;
    end
  end

  assign wm = wm_q;
`else
  logic unused_wm_clr;
  assign unused_wm_clr = wm_clr;
  assign wm            = TOP_ADDR;
`endif

endmodule

// File: tb/tb_sp_guarded.sv
// Scoreboard bench for sp_guarded: directed commands push hand-computed expectations,
// a monitor pops and compares one cycle later.
module tb_sp_guarded;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] ld_val = 16'h0000;
  logic        clr_fault = 1'b0;
  logic        wm_clr = 1'b0;
  logic [15:0] out;
  logic        empty;
  logic        full;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [15:0] wm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] out;
    logic        empty;
    logic        full;
    logic        fault;
    logic [1:0]  cause;
    logic [15:0] wm;
  } exp_t;

  exp_t sb[$];
  int   step_id = 0;

  sp_guarded dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .ld(ld), .ld_val(ld_val),
    .clr_fault(clr_fault), .out(out), .empty(empty), .full(full), .fault(fault),
    .fault_cause(fault_cause), .wm(wm), .wm_clr(wm_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] wmx(input logic [15:0] v);
`ifdef SP_WATERMARK_EN
    return v;
`else
    return 16'h01FF;
`endif
  endfunction

  task automatic check(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Drive one command for one clock and queue its expected post-edge state.
  task automatic step(input logic r, input logic i, input logic d, input logic l,
                      input logic [15:0] lv, input logic c, input logic w,
                      input logic [15:0] e_out, input logic e_emp, input logic e_full,
                      input logic e_flt, input logic [1:0] e_cause, input logic [15:0] e_wm);
    exp_t e;
    @(negedge clk);
    rst = r; inc = i; dec = d; ld = l; ld_val = lv; clr_fault = c; wm_clr = w;
    step_id++;
    e.id = step_id; e.out = e_out; e.empty = e_emp; e.full = e_full;
    e.fault = e_flt; e.cause = e_cause; e.wm = e_wm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out",   e.id, out, e.out);
        check("empty", e.id, {15'b0, empty}, {15'b0, e.empty});
        check("full",  e.id, {15'b0, full}, {15'b0, e.full});
        check("fault", e.id, {15'b0, fault}, {15'b0, e.fault});
        check("cause", e.id, {14'b0, fault_cause}, {14'b0, e.cause});
        check("wm",    e.id, wm, e.wm);
      end
    end
  end

  initial begin : stimulus
    int budget;
    //   rst inc dec ld ld_val    clr wmc   out       emp full flt cause  wm
    step(1, 0, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FF));
    step(0, 0, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FF));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FE, 0, 0, 0, 2'b00, wmx(16'h01FE));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FE));
    step(0, 1, 1, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FE));
    // underflow, ignored push while frozen, clear, then push works again
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 1, 2'b10, wmx(16'h01FE));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 1, 2'b10, wmx(16'h01FE));
    step(0, 0, 0, 0, 16'h0000, 1, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FE));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FE, 0, 0, 0, 2'b00, wmx(16'h01FE));
    // load to bottom, overflow, recover by valid load
    step(0, 0, 0, 1, 16'h0100, 0, 0,  16'h0100, 0, 1, 0, 2'b00, wmx(16'h0100));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h0100, 0, 1, 1, 2'b01, wmx(16'h0100));
    step(0, 0, 0, 1, 16'h0180, 0, 0,  16'h0180, 0, 0, 0, 2'b00, wmx(16'h0100));
    // bad loads, above and below range, and bad load beating clr_fault
    step(0, 0, 0, 1, 16'h0200, 0, 0,  16'h0180, 0, 0, 1, 2'b11, wmx(16'h0100));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h0180, 0, 0, 1, 2'b11, wmx(16'h0100));
    step(0, 0, 0, 1, 16'h00FF, 1, 0,  16'h0180, 0, 0, 1, 2'b11, wmx(16'h0100));
    step(0, 0, 0, 1, 16'h01FF, 1, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h0100));
    step(0, 0, 0, 0, 16'h0000, 1, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h0100));
    // reset overrides simultaneous commands, including while faulted
    step(1, 1, 0, 1, 16'h0100, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FF));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 1, 2'b10, wmx(16'h01FF));
    step(1, 0, 0, 0, 16'h0000, 0, 0,  16'h01FF, 1, 0, 0, 2'b00, wmx(16'h01FF));
    // watermark: 5 pushes, 3 pops, clear
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FE, 0, 0, 0, 2'b00, wmx(16'h01FE));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FD, 0, 0, 0, 2'b00, wmx(16'h01FD));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FC, 0, 0, 0, 2'b00, wmx(16'h01FC));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FB, 0, 0, 0, 2'b00, wmx(16'h01FB));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h01FA, 0, 0, 0, 2'b00, wmx(16'h01FA));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FB, 0, 0, 0, 2'b00, wmx(16'h01FA));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FC, 0, 0, 0, 2'b00, wmx(16'h01FA));
    step(0, 1, 0, 0, 16'h0000, 0, 0,  16'h01FD, 0, 0, 0, 2'b00, wmx(16'h01FA));
    step(0, 0, 0, 0, 16'h0000, 0, 1,  16'h01FD, 0, 0, 0, 2'b00, wmx(16'h01FD));
    step(0, 0, 1, 0, 16'h0000, 0, 1,  16'h01FC, 0, 0, 0, 2'b00, wmx(16'h01FC));
    // load one above bottom: not full until a push reaches bottom
    step(0, 0, 0, 1, 16'h0101, 0, 0,  16'h0101, 0, 0, 0, 2'b00, wmx(16'h0101));
    step(0, 0, 1, 0, 16'h0000, 0, 0,  16'h0100, 0, 1, 0, 2'b00, wmx(16'h0100));

    @(negedge clk);
    rst = 0; inc = 0; dec = 0; ld = 0; ld_val = 16'h0000; clr_fault = 0; wm_clr = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_guarded.md
Name: sp_guarded

Overview:
- Parametrised successor to the 16-bit stack pointer: a registered SP for a full-descending stack, with a configurable step, address range limits and load capability.
- Detects overflow, underflow and illegal loads, and freezes in a FAULT state until software clears it.
- Sits beside the register file in the datapath. The control unit drives push (dec) and pop (inc); the address mux reads `out`.

Parameters:
- WIDTH, 16, pointer width in bits
- TOP_ADDR, 16'h01FF, reset value and empty-stack address (highest legal SP)
- BOTTOM_ADDR, 16'h0100, lowest legal SP (stack full)
- STEP, 1, amount added or subtracted per inc/dec (1..TOP_ADDR-BOTTOM_ADDR)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- inc  in  1  pop: SP += STEP
- dec  in  1  push: SP -= STEP
- ld  in  1  load SP from ld_val
- ld_val  in  WIDTH  value to load
- clr_fault  in  1  clear fault, return to RUN
- out  out  WIDTH  current stack pointer (registered)
- empty  out  1  (TOP_ADDR - out) < STEP, combinational from out
- full  out  1  (out - BOTTOM_ADDR) < STEP, combinational from out
- fault  out  1  registered; 1 while in FAULT
- fault_cause  out  2  registered; 00 none, 01 overflow, 10 underflow, 11 bad load
- wm  out  WIDTH  low-water mark (see Optional Feature)
- wm_clr  in  1  reset low-water mark to out

Behaviour:
- Reset (rst=1 at edge): out=TOP_ADDR, state=RUN, fault=0, fault_cause=00, wm=TOP_ADDR. rst overrides every other input, including mid-fault.
- Latency: a command sampled at edge N is visible on out after edge N; empty and full follow in the same cycle.
- Arithmetic: limit comparisons are done in WIDTH+1 bits, so no wrap-around is possible. out never leaves [BOTTOM_ADDR, TOP_ADDR].
- Priority in RUN: ld > (inc,dec) > clr_fault.
  - ld with BOTTOM_ADDR <= ld_val <= TOP_ADDR: out=ld_val.
  - ld with ld_val out of range: out unchanged, go to FAULT, cause=11.
  - inc and dec together: net zero, out unchanged, no fault.
  - dec alone, full=0: out -= STEP.
  - dec alone, full=1: out unchanged, go to FAULT, cause=01.
  - inc alone, empty=0: out += STEP.
  - inc alone, empty=1: out unchanged, go to FAULT, cause=10.
  - clr_fault in RUN: no effect.
- FAULT state:
  - inc and dec are ignored; out holds.
  - clr_fault: go to RUN, fault=0, cause=00.
  - A valid ld is accepted and also returns to RUN with cause=00.
  - An invalid ld keeps FAULT with cause=11.
  - If ld and clr_fault are asserted together, ld rules decide the outcome.
- fault_cause is updated only on entry to FAULT, on exit from FAULT, or by an invalid ld while in FAULT.

Optional Feature:
- Macro: SP_WATERMARK_EN.
- When defined:
  - wm is a register holding the minimum out value since reset or wm_clr (deepest stack usage).
  - Each edge: if wm_clr, wm <= next out; else wm <= min(wm, next out).
- When undefined:
  - No register is built; wm is tied to TOP_ADDR and wm_clr is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- rst=1 for one edge, then idle -> out=16'h01FF, empty=1, full=0, fault=0, fault_cause=00.
- From reset, dec one cycle -> out=16'h01FE, empty=0. Then inc one cycle -> out=16'h01FF. Then inc and dec together -> out holds 16'h01FF, no fault.
- From reset, inc -> fault=1, cause=10, out=16'h01FF. Then dec -> out still 16'h01FF (ignored). Then clr_fault -> fault=0, cause=00. Then dec -> out=16'h01FE.
- ld with ld_val=16'h0100 -> out=16'h0100, full=1. Then dec -> fault=1, cause=01, out=16'h0100. Then ld with ld_val=16'h0180 -> RUN, out=16'h0180.
- ld with ld_val=16'h0200 -> cause=11, out unchanged. Then rst asserted during FAULT -> out=16'h01FF, fault=0.
- With SP_WATERMARK_EN defined, 5 decs then 3 incs -> out=16'h01FD, wm=16'h01FA. Then wm_clr -> wm=16'h01FD. With the macro undefined, wm=16'h01FF throughout.
